// File: rtl/rf_uart_drain.sv
// Drains the RF receive FIFO into framed packets (SYNC, LEN, payload, XOR checksum)
// and serialises each frame 8N1 on uart_tx.
module rf_uart_drain #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          MAX_PAYLOAD  = 16,
    parameter int          GAP_CYCLES   = 1024,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       uart_tx,
    output logic       busy,
    output logic       pkt_sent
);

    localparam int BUF_AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int BUF_DEPTH = 1 << BUF_AW;
    localparam int BIT_CW    = $clog2(CLKS_PER_BIT);
    localparam int GAP_CW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_CW-1:0] BIT_RELOAD = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST   = GAP_CW'(GAP_CYCLES - 1);
    localparam logic [8:0]        MAX_P      = 9'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_CAP,
        S_WAIT_GAP,
        S_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          buf_q [BUF_DEPTH];
    logic [7:0]          buf_d [BUF_DEPTH];
    logic [8:0]          byte_idx_q, byte_idx_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                fifo_rd_en_q, fifo_rd_en_d;
    logic                uart_tx_q, uart_tx_d;
    logic                busy_q, busy_d;
    logic                pkt_sent_q, pkt_sent_d;

    logic                start_send;
    logic [8:0]          nxt_idx;
    logic [8:0]          last_idx;
    logic [BUF_AW-1:0]   data_sel;
    logic [7:0]          next_byte;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        csum_d      = csum_q;
        buf_d       = buf_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        bit_cnt_d   = bit_cnt_q;
        tx_byte_d   = tx_byte_q;
        uart_tx_d   = uart_tx_q;
        pkt_sent_d  = 1'b0;
        start_send  = 1'b0;

        // Frame byte k: 0 = SYNC, 1 = LEN, 2..LEN+1 = payload, LEN+2 = checksum.
        nxt_idx  = byte_idx_q + 9'd1;
        last_idx = {1'b0, count_q} + 9'd2;
        data_sel = BUF_AW'(nxt_idx - 9'd2);
        if (nxt_idx == 9'd1) begin
            next_byte = count_q;
        end else if (nxt_idx == last_idx) begin
            next_byte = csum_q ^ count_q;
        end else begin
            next_byte = buf_q[data_sel];
        end

        case (state_q)
            S_IDLE: begin
                uart_tx_d = 1'b1;
                if (tx_enable && !fifo_empty) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                buf_d[count_q[BUF_AW-1:0]] = fifo_dout;
                count_d = count_q + 8'd1;
                csum_d  = csum_q ^ fifo_dout;
                gap_d   = '0;
                if (({1'b0, count_q} + 9'd1) == MAX_P) begin
                    start_send = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_WAIT_GAP;
                end
            end
            S_WAIT_GAP: begin
                if (!fifo_empty) begin
                    gap_d   = '0;
                    state_d = S_RD_REQ;
                end else if (gap_q == GAP_LAST) begin
                    start_send = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_CW'(1);
                end
            end
            S_SEND: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BIT_CW'(1);
                end else begin
                    bit_cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 4'd9) begin
                        if (byte_idx_q == last_idx) begin
                            state_d    = S_IDLE;
                            uart_tx_d  = 1'b1;
                            pkt_sent_d = 1'b1;
                            count_d    = '0;
                            csum_d     = '0;
                            gap_d      = '0;
                        end else begin
                            byte_idx_d = nxt_idx;
                            tx_byte_d  = next_byte;
                            bit_idx_d  = '0;
                            uart_tx_d  = 1'b0;
                        end
                    end else if (bit_idx_q == 4'd8) begin
                        bit_idx_d = 4'd9;
                        uart_tx_d = 1'b1;
                    end else begin
                        // bit_idx_q 0..7: the next bit to drive is data bit bit_idx_q
                        bit_idx_d = bit_idx_q + 4'd1;
                        uart_tx_d = tx_byte_q[bit_idx_q[2:0]];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_send) begin
            state_d    = S_SEND;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            bit_cnt_d  = BIT_RELOAD;
            tx_byte_d  = SYNC_BYTE;
            uart_tx_d  = 1'b0;
        end

        fifo_rd_en_d = (state_d == S_RD_REQ);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            gap_q        <= '0;
            csum_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            bit_cnt_q    <= '0;
            tx_byte_q    <= '0;
            fifo_rd_en_q <= 1'b0;
            uart_tx_q    <= 1'b1;
            busy_q       <= 1'b0;
            pkt_sent_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            csum_q       <= csum_d;
            buf_q        <= buf_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_byte_q    <= tx_byte_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            uart_tx_q    <= uart_tx_d;
            busy_q       <= busy_d;
            pkt_sent_q   <= pkt_sent_d;
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign uart_tx    = uart_tx_q;
    assign busy       = busy_q;
    assign pkt_sent   = pkt_sent_q;

endmodule

// File: tb/tb_rf_uart_drain.sv
// Scoreboard bench for rf_uart_drain: a FIFO model feeds the DUT, a UART decoder
// checks every frame byte, bit width and frame timing against queued expectations.
module tb_rf_uart_drain;

    localparam int CPB  = 4;
    localparam int MAXP = 4;
    localparam int GAP  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       uart_tx;
    logic       busy;
    logic       pkt_sent;

    rf_uart_drain #(
        .CLKS_PER_BIT (CPB),
        .MAX_PAYLOAD  (MAXP),
        .GAP_CYCLES   (GAP),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .pkt_sent   (pkt_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, one-cycle latency
    logic [7:0] fifo_q[$];
    int         fifo_cnt = 0;
    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_dout <= fifo_q.pop_front();
            fifo_cnt  <= fifo_cnt - 1;
        end
    end

    logic [7:0] exp_q[$];
    int exp_frames   = 0;
    int total_pushed = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state
    bit         mon_active = 0;
    int         mon_bit = 0, mon_sub = 0;
    bit         mon_lvl = 0, mon_werr = 0;
    logic [7:0] mon_data = 0;
    int         mon_start = 0;
    int         frame_pos = 0, frame_len = 1000, frame_start = 0, last_end = 0;
    int         last_rd = 0, rd_pulses = 0, pkts = 0, bytes_rx = 0, viol = 0;
    bit         rd_prev = 0, pkt_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
            frame_pos  = 0;
            rd_prev    = 0;
            pkt_prev   = 0;
        end else begin
            if (fifo_rd_en) begin
                rd_pulses++;
                last_rd = cyc;
                if (fifo_empty || rd_prev || mon_active || frame_pos != 0) viol++;
            end
            rd_prev = fifo_rd_en;
            if (!busy && !uart_tx) viol++;

            if (pkt_sent) begin
                pkts++;
                chk(!pkt_prev && frame_pos == 0 && !mon_active, "pkt_sent_pulse", pkt_prev, 0);
                chk(cyc - frame_start == frame_len * 10 * CPB, "frame_length",
                    cyc - frame_start, frame_len * 10 * CPB);
            end
            pkt_prev = pkt_sent;

            if (mon_active) begin
                if (mon_sub == 0) begin
                    mon_lvl = uart_tx;
                    if (mon_bit >= 1 && mon_bit <= 8) mon_data = {uart_tx, mon_data[7:1]};
                end else if (uart_tx !== mon_lvl) begin
                    mon_werr = 1;
                end
                if (mon_sub == CPB - 1) begin
                    if (mon_bit == 9) begin
                        mon_active = 0;
                        last_end   = cyc;
                        bytes_rx++;
                        chk(!mon_werr && mon_lvl, "bit_width_stop", {mon_werr, mon_lvl}, 1);
                        if (exp_q.size() == 0) begin
                            chk(0, "unexpected_byte", mon_data, 0);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            chk(mon_data == e, "uart_byte", mon_data, e);
                        end
                        if (frame_pos == 1) begin
                            frame_len = int'(mon_data) + 3;
                            chk(frame_start - last_rd == ((mon_data == MAXP) ? 2 : GAP + 2),
                                "send_latency", frame_start - last_rd,
                                (mon_data == MAXP) ? 2 : GAP + 2);
                        end
                        frame_pos++;
                        if (frame_pos >= 2 && frame_pos == frame_len) frame_pos = 0;
                    end else begin
                        mon_bit++;
                        mon_sub = 0;
                    end
                end else begin
                    mon_sub++;
                end
            end else if (uart_tx === 1'b0) begin
                mon_active = 1;
                mon_bit    = 0;
                mon_sub    = 1;
                mon_lvl    = 0;
                mon_werr   = 0;
                mon_start  = cyc;
                if (frame_pos == 0) begin
                    frame_start = cyc;
                    frame_len   = 1000;
                end else begin
                    chk(cyc == last_end + 1, "back_to_back", cyc - last_end, 1);
                end
            end else if (frame_pos != 0 && cyc > last_end + 1) begin
                chk(0, "back_to_back", cyc - last_end, 1);
                frame_pos = 0;
            end
        end
    end

    // Reference model: each burst is cut into MAXP-sized packets, in FIFO order
    task automatic expect_frame(input logic [7:0] d[$]);
        logic [7:0] cs;
        cs = 8'(d.size());
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(d.size()));
        foreach (d[i]) begin
            exp_q.push_back(d[i]);
            cs = cs ^ d[i];
        end
        exp_q.push_back(cs);
        exp_frames++;
    endtask

    task automatic push_fifo(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_cnt = fifo_cnt + 1;
        total_pushed++;
    endtask

    task automatic push_burst(input logic [7:0] d[$]);
        logic [7:0] chunk[$];
        for (int i = 0; i < d.size(); i++) begin
            chunk.push_back(d[i]);
            if (chunk.size() == MAXP || i == d.size() - 1) begin
                expect_frame(chunk);
                chunk.delete();
            end
        end
        foreach (d[i]) push_fifo(d[i]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(!busy && fifo_cnt == 0 && exp_q.size() == 0 && !mon_active &&
                 frame_pos == 0 && pkts == exp_frames) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            chk(0, "wait_idle_timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_frames = pkts;
        end
        repeat (3) @(negedge clk);
        chk(busy == 0, "busy_after_frame", busy, 0);
        chk(pkts == exp_frames, "pkt_count", pkts, exp_frames);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d[$];
        int snap_rd, snap_rx, n, len;
        bit busy_seen;

        rst = 1'b1;
        tx_enable = 1'b0;
        fifo_dout = 8'h00;
        repeat (3) @(negedge clk);
        chk(uart_tx == 1'b1, "reset_uart_tx", uart_tx, 1);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(fifo_rd_en == 1'b0, "reset_rd_en", fifo_rd_en, 0);
        chk(pkt_sent == 1'b0, "reset_pkt_sent", pkt_sent, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two bytes closed by the idle gap
        tx_enable = 1'b1;
        d = '{8'h11, 8'h22};
        push_burst(d);
        wait_idle(2000);

        // Six bytes: one full packet then a short one
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_burst(d);
        wait_idle(3000);
        chk(rd_pulses == total_pushed, "rd_pulse_count", rd_pulses, total_pushed);

        // Late byte during the gap joins the same packet
        d = '{8'h3C, 8'h7E};
        expect_frame(d);
        push_fifo(8'h3C);
        snap_rd = rd_pulses;
        n = 0;
        while (rd_pulses == snap_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(n < 50, "first_read_seen", n, 0);
        repeat (5) @(negedge clk);
        push_fifo(8'h7E);
        wait_idle(2000);

        // Empty FIFO with tx_enable toggling: nothing happens
        snap_rd = rd_pulses;
        snap_rx = bytes_rx;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tx_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy || !uart_tx) busy_seen = 1;
        end
        chk(!busy_seen, "empty_idle_quiet", busy_seen, 0);
        chk(rd_pulses == snap_rd, "empty_no_reads", rd_pulses, snap_rd);
        chk(bytes_rx == snap_rx, "empty_no_tx", bytes_rx, snap_rx);

        // tx_enable low holds off a non-empty FIFO
        tx_enable = 1'b0;
        d = '{8'h33, 8'h44};
        push_burst(d);
        repeat (20) @(negedge clk);
        chk(rd_pulses == snap_rd && busy == 0, "enable_gate", rd_pulses, snap_rd);
        tx_enable = 1'b1;
        wait_idle(2000);

        // Reset in the middle of the LEN byte
        d = '{8'($urandom), 8'($urandom)};
        push_burst(d);
        n = 0;
        while (!(mon_active && frame_pos == 1 && mon_bit == 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(n < 500, "reach_len_byte", n, 0);
        #2 rst = 1'b1;
        #1;
        chk(uart_tx == 1'b1, "async_rst_uart_tx", uart_tx, 1);
        chk(busy == 1'b0, "async_rst_busy", busy, 0);
        exp_q.delete();
        exp_frames = pkts;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        snap_rx = bytes_rx;
        repeat (60) @(negedge clk);
        chk(bytes_rx == snap_rx && !mon_active, "post_reset_silent", bytes_rx, snap_rx);
        chk(busy == 0, "post_reset_busy", busy, 0);
        d = '{8'($urandom), 8'($urandom), 8'($urandom)};
        push_burst(d);
        wait_idle(2000);

        // Randomised bursts; short bursts drop tx_enable once the packet has started
        for (int it = 0; it < 12; it++) begin
            len = $urandom_range(1, 2 * MAXP + 1);
            d.delete();
            for (int k = 0; k < len; k++) d.push_back(8'($urandom));
            push_burst(d);
            if (len <= MAXP && $urandom_range(0, 1) == 1) begin
                n = 0;
                while (!busy && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                tx_enable = 1'b0;
            end
            wait_idle(4000);
            tx_enable = 1'b1;
        end

        chk(viol == 0, "rd_en_and_busy_protocol", viol, 0);
        chk(rd_pulses == total_pushed, "total_reads", rd_pulses, total_pushed);
        chk(bytes_rx > 0 && exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
